// File: rtl/stopwatch_pkg.sv
// Shared constants for the stopwatch display path: digit count, scan FSM states and the
// seven-segment glyph table (active-high, bit 0 = segment a).
package stopwatch_pkg;

    localparam int unsigned NUM_DIGITS = 8;
    localparam int unsigned DP_BIT     = 7;

    typedef enum logic [1:0] {
        StOff   = 2'd0,
        StBlank = 2'd1,
        StShow  = 2'd2
    } scan_state_e;

    // Index = nibble value; 0-9 decimal, A-F as A b C d E F.
    localparam logic [6:0] GLYPHS [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/seg7_decode.sv
// Combinational nibble-to-seven-segment decoder with decimal point; active-high output.
module seg7_decode
    import stopwatch_pkg::*;
(
    input  logic [3:0] nibble_i,
    input  logic       dp_i,
    output logic [7:0] seg_o
);

    always_comb begin
        seg_o         = {1'b0, GLYPHS[nibble_i]};
        seg_o[DP_BIT] = dp_i;
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Eight-digit seven-segment scanner: steps one digit per scan tick with a blank gap between
// digits, and latches a coherent snapshot of the display data at the start of each frame.
module seg_scan_driver
    import stopwatch_pkg::*;
#(
    parameter int unsigned BLANK_CYCLES   = 1000,
    parameter bit          SEG_ACTIVE_LOW = 1'b0,
    parameter bit          AN_ACTIVE_LOW  = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    scan_clk_in,
    input  logic [4*NUM_DIGITS-1:0] digits_bcd,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic                    blank_lz,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [7:0]              seg_lo,
    output logic [7:0]              seg_hi,
    output logic                    frame_start
);

    localparam logic [15:0] BlankLast = 16'(BLANK_CYCLES - 1);

    logic sync1_q, sync2_q, prev_q, tick;

    scan_state_e                 state_q, state_d;
    logic [15:0]                 cnt_q, cnt_d;
    logic [2:0]                  idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0]     snap_digits_q, snap_digits_d;
    logic [NUM_DIGITS-1:0]       snap_dp_q, snap_dp_d;
    logic [NUM_DIGITS-1:0]       snap_en_q, snap_en_d;
    logic                        snap_lz_q, snap_lz_d;
    logic                        frame_start_q, frame_start_d;

    logic [NUM_DIGITS-1:0]       an_q, an_d;
    logic [7:0]                  seg_lo_q, seg_lo_d, seg_hi_q, seg_hi_d;

    logic [3:0]                  nibble;
    logic [4*NUM_DIGITS-1:0]     upper_digits;
    logic [NUM_DIGITS-1:0]       upper_dp;
    logic                        lz_blank, dark;
    logic [7:0]                  dec_seg;

    // The scan wave is asynchronous data: synchronise, then detect rising edges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= scan_clk_in;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign tick = sync2_q & ~prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StOff;
            cnt_q         <= '0;
            idx_q         <= 3'd7;
            snap_digits_q <= '0;
            snap_dp_q     <= '0;
            snap_en_q     <= '0;
            snap_lz_q     <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            snap_digits_q <= snap_digits_d;
            snap_dp_q     <= snap_dp_d;
            snap_en_q     <= snap_en_d;
            snap_lz_q     <= snap_lz_d;
            frame_start_q <= frame_start_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        idx_d         = idx_q;
        snap_digits_d = snap_digits_q;
        snap_dp_d     = snap_dp_q;
        snap_en_d     = snap_en_q;
        snap_lz_d     = snap_lz_q;
        frame_start_d = 1'b0;
        unique case (state_q)
            StOff, StShow: begin
                if (tick) begin
                    state_d = StBlank;
                    cnt_d   = '0;
                end
            end
            StBlank: begin
                // Ticks during the gap are ignored; only the counter ends it.
                if (cnt_q == BlankLast) begin
                    idx_d   = idx_q + 3'd1;
                    state_d = StShow;
                    if (idx_d == 3'd0) begin
                        snap_digits_d = digits_bcd;
                        snap_dp_d     = dp_mask;
                        snap_en_d     = digit_en;
                        snap_lz_d     = blank_lz;
                        frame_start_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = StOff;
        endcase
    end

    // A digit is a leading zero when it and every digit above it is 0 with no dp lit.
    assign nibble       = snap_digits_q[{idx_q, 2'b00} +: 4];
    assign upper_digits = snap_digits_q >> {idx_q, 2'b00};
    assign upper_dp     = snap_dp_q >> idx_q;
    assign lz_blank     = snap_lz_q && (idx_q != 3'd0) && (upper_digits == '0) && (upper_dp == '0);
    assign dark         = !snap_en_q[idx_q] || lz_blank;

    seg7_decode u_decode (
        .nibble_i (nibble),
        .dp_i     (snap_dp_q[idx_q]),
        .seg_o    (dec_seg)
    );

    always_comb begin
        an_d     = '0;
        seg_lo_d = '0;
        seg_hi_d = '0;
        if (state_q == StShow && !dark) begin
            an_d[idx_q] = 1'b1;
            if (idx_q[2]) begin
                seg_hi_d = dec_seg;
            end else begin
                seg_lo_d = dec_seg;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an_q     <= '0;
            seg_lo_q <= '0;
            seg_hi_q <= '0;
        end else begin
            an_q     <= an_d;
            seg_lo_q <= seg_lo_d;
            seg_hi_q <= seg_hi_d;
        end
    end

    assign an          = an_q ^ {NUM_DIGITS{AN_ACTIVE_LOW}};
    assign seg_lo      = seg_lo_q ^ {8{SEG_ACTIVE_LOW}};
    assign seg_hi      = seg_hi_q ^ {8{SEG_ACTIVE_LOW}};
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver: a normal-polarity and an inverted-polarity instance share
// stimulus; each scan slot is 2000 clk with the scan wave driven from the main sequence.
module tb_seg_scan_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic        scan_clk_in;
    logic [31:0] digits_bcd;
    logic [7:0]  dp_mask, digit_en;
    logic        blank_lz;
    logic [7:0]  an, seg_lo, seg_hi, an2, seg_lo2, seg_hi2;
    logic        frame_start, frame_start2;

    int n_vec = 0;
    int n_err = 0;
    int fs_cnt = 0;

    always #5 clk = ~clk;

    always @(posedge clk) if (frame_start) fs_cnt <= fs_cnt + 1;

    seg_scan_driver #(.BLANK_CYCLES(1000), .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b0)) dut (
        .clk(clk), .rst(rst), .scan_clk_in(scan_clk_in), .digits_bcd(digits_bcd),
        .dp_mask(dp_mask), .digit_en(digit_en), .blank_lz(blank_lz),
        .an(an), .seg_lo(seg_lo), .seg_hi(seg_hi), .frame_start(frame_start)
    );

    seg_scan_driver #(.BLANK_CYCLES(1000), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)) dut_inv (
        .clk(clk), .rst(rst), .scan_clk_in(scan_clk_in), .digits_bcd(digits_bcd),
        .dp_mask(dp_mask), .digit_en(digit_en), .blank_lz(blank_lz),
        .an(an2), .seg_lo(seg_lo2), .seg_hi(seg_hi2), .frame_start(frame_start2)
    );

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One scan slot: gap sampled 500 clk after the rising edge, lit digit at 1500.
    task automatic slot(input string tag, input int idx, input logic [7:0] glyph, input bit lit);
        logic [7:0] e_an, e_lo, e_hi;
        e_an = 8'h00; e_lo = 8'h00; e_hi = 8'h00;
        if (lit) begin
            e_an = 8'h01 << idx;
            if (idx < 4) e_lo = glyph; else e_hi = glyph;
        end
        scan_clk_in = 1'b1;
        cyc(500);
        chk($sformatf("%s gap d%0d", tag, idx), {8'h00, an, seg_lo, seg_hi}, 32'h0);
        cyc(500);
        scan_clk_in = 1'b0;
        cyc(500);
        chk($sformatf("%s lit d%0d", tag, idx), {8'h00, an, seg_lo, seg_hi},
            {8'h00, e_an, e_lo, e_hi});
        cyc(500);
    endtask

    logic [7:0] ga [8] = '{8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F};
    logic [7:0] gb [8] = '{8'h6D, 8'h3F, 8'h4F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    logic [7:0] gc [8] = '{8'h6D, 8'h3F, 8'h4F, 8'h3F, 8'h3F, 8'hBF, 8'h00, 8'h00};

    initial begin
        rst = 1'b1; scan_clk_in = 1'b0;
        digits_bcd = 32'h8765_4321; dp_mask = 8'h00; digit_en = 8'hFF; blank_lz = 1'b0;
        cyc(5);
        chk("reset outputs", {7'h0, frame_start, an, seg_lo, seg_hi}, 32'h0);
        chk("reset outputs inv", {8'h00, an2, seg_lo2, seg_hi2}, 32'h00FF_FFFF);
        rst = 1'b0;
        cyc(50);

        // Frame A; inputs for frame B change mid-frame and must not show until it starts.
        for (int i = 0; i < 8; i++) begin
            if (i == 1) begin
                digits_bcd = 32'h0000_0305; blank_lz = 1'b1; dp_mask = 8'h00;
            end
            slot("frameA", i, ga[i], 1'b1);
            if (i == 0) chk("frame_start count A", fs_cnt, 1);
        end

        for (int i = 0; i < 8; i++) begin
            if (i == 1) dp_mask = 8'h20;
            slot("frameB lz", i, gb[i], i < 3);
        end

        for (int i = 0; i < 8; i++) begin
            if (i == 1) begin
                digits_bcd = 32'h1111_1111; blank_lz = 1'b0; dp_mask = 8'h00;
            end
            slot("frameC lz dp", i, gc[i], i < 6);
        end

        for (int i = 0; i < 8; i++) begin
            if (i == 3) digits_bcd = 32'h2222_2222;
            slot("frameD coherent", i, 8'h06, 1'b1);
        end

        slot("frameE", 0, 8'h5B, 1'b1);
        chk("frame_start count E", fs_cnt, 5);
        slot("frameE", 1, 8'h5B, 1'b1);

        // Reset while digit 2 is lit: outputs must drop without waiting for a clock edge.
        scan_clk_in = 1'b1;
        cyc(1500);
        chk("pre-reset d2", {8'h00, an, seg_lo, seg_hi}, 32'h0004_5B00);
        #2 rst = 1'b1;
        #1;
        chk("async reset dark", {8'h00, an, seg_lo, seg_hi}, 32'h0);
        chk("async reset dark inv", {8'h00, an2, seg_lo2, seg_hi2}, 32'h00FF_FFFF);
        scan_clk_in = 1'b0;
        cyc(5);
        rst = 1'b0;
        cyc(100);
        scan_clk_in = 1'b1;
        cyc(998);
        chk("restart still dark", {8'h00, an, seg_lo, seg_hi}, 32'h0);
        cyc(10);
        chk("restart lit d0", {8'h00, an, seg_lo, seg_hi}, 32'h0001_5B00);
        scan_clk_in = 1'b0;
        cyc(992);

        // Extra rising edge inside the gap must neither restart it nor advance the digit.
        scan_clk_in = 1'b1; cyc(250);
        scan_clk_in = 1'b0; cyc(250);
        scan_clk_in = 1'b1; cyc(250);
        scan_clk_in = 1'b0; cyc(248);
        chk("glitch gap dark", {8'h00, an, seg_lo, seg_hi}, 32'h0);
        cyc(12);
        chk("glitch lit d1", {8'h00, an, seg_lo, seg_hi}, 32'h0002_5B00);
        cyc(990);

        // Polarity: digit 0 = 8 with dp, digit 1 disabled.
        digits_bcd = 32'h0000_0008; dp_mask = 8'h01; digit_en = 8'hFD; blank_lz = 1'b0;
        rst = 1'b1;
        cyc(3);
        rst = 1'b0;
        cyc(20);
        scan_clk_in = 1'b1;
        cyc(500);
        chk("inv gap all ones", {8'h00, an2, seg_lo2, seg_hi2}, 32'h00FF_FFFF);
        cyc(500);
        scan_clk_in = 1'b0;
        cyc(500);
        chk("8dp lit", {8'h00, an, seg_lo, seg_hi}, 32'h0001_FF00);
        chk("8dp lit inv", {8'h00, an2, seg_lo2, seg_hi2}, 32'h00FE_00FF);
        cyc(500);
        scan_clk_in = 1'b1;
        cyc(1500);
        chk("disabled d1 dark", {8'h00, an, seg_lo, seg_hi}, 32'h0);
        chk("disabled d1 dark inv", {8'h00, an2, seg_lo2, seg_hi2}, 32'h00FF_FFFF);
        scan_clk_in = 1'b0;
        cyc(20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
